// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU hazard scoreboard: opcode classes, instruction
// field positions and the source-use descriptor.
package cpu_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 24;
  localparam int DEST_MSB = 23;
  localparam int DEST_LSB = 20;
  localparam int SRCA_MSB = 19;
  localparam int SRCA_LSB = 16;
  localparam int SRCB_MSB = 15;
  localparam int SRCB_LSB = 12;

  localparam logic [7:0] OP_L_11 = 8'h11;
  localparam logic [7:0] OP_L_13 = 8'h13;
  localparam logic [7:0] OP_L_15 = 8'h15;
  localparam logic [7:0] OP_L_27 = 8'h27;
  localparam logic [7:0] OP_L_23 = 8'h23;
  localparam logic [7:0] OP_L_25 = 8'h25;
  localparam logic [7:0] OP_L_85 = 8'h85;
  localparam logic [7:0] OP_L_87 = 8'h87;

  localparam logic [7:0] OP_R_10 = 8'h10;
  localparam logic [7:0] OP_R_12 = 8'h12;
  localparam logic [7:0] OP_R_14 = 8'h14;
  localparam logic [7:0] OP_R_16 = 8'h16;
  localparam logic [7:0] OP_R_20 = 8'h20;
  localparam logic [7:0] OP_R_22 = 8'h22;
  localparam logic [7:0] OP_R_24 = 8'h24;

  localparam int NUM_L_OPS = 8;
  localparam int NUM_R_OPS = 7;

  // L-type opcodes read src A only; R-type read src A and src B.
  localparam logic [NUM_L_OPS-1:0][7:0] L_OPS = {
    OP_L_11, OP_L_13, OP_L_15, OP_L_27, OP_L_23, OP_L_25, OP_L_85, OP_L_87
  };
  localparam logic [NUM_R_OPS-1:0][7:0] R_OPS = {
    OP_R_10, OP_R_12, OP_R_14, OP_R_16, OP_R_20, OP_R_22, OP_R_24
  };

  typedef struct packed {
    logic use_a;
    logic use_b;
  } src_use_t;

endpackage

// File: rtl/cpu_src_decode.sv
// Combinational opcode-to-source-usage decode for the hazard scoreboard.
module cpu_src_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output src_use_t   src_use
);

  always_comb begin
    src_use = '0;
    for (int i = 0; i < NUM_L_OPS; i++) begin
      if (opcode == L_OPS[i]) src_use.use_a = 1'b1;
    end
    for (int i = 0; i < NUM_R_OPS; i++) begin
      if (opcode == R_OPS[i]) begin
        src_use.use_a = 1'b1;
        src_use.use_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_hazard_sb.sv
// Scoreboard hazard unit: per-register pending-write counters plus a timed
// jump/branch stall. Optional writeback bypass under CPU_HAZARD_WB_BYPASS_EN.
module cpu_hazard_sb
  import cpu_pkg::*;
#(
  parameter int NUM_REGS        = 16,
  parameter int PIPE_DEPTH      = 3,
  parameter int JB_STALL_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        if_valid,
  input  logic [31:0]                 if_instr,
  input  logic                        if_wrt_en,
  input  logic                        if_jb,
  input  logic                        wb_wrt_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_wrt_reg,
  input  logic                        jb_resolve,
  input  logic                        flush,
  output logic                        issue_fire,
  output logic                        rd_wrt_stall,
  output logic                        jb_stall,
  output logic                        sb_err
);

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam int JB_W  = $clog2(JB_STALL_CYCLES + 1);

  logic [CNT_W-1:0] pending     [NUM_REGS];
  logic [CNT_W-1:0] pending_nxt [NUM_REGS];
  logic [JB_W-1:0]  jb_cnt, jb_nxt;
  logic             err_set;
  logic             inc, dec;
  logic             a_busy, b_busy;

  logic [7:0]       opcode;
  logic [REG_W-1:0] dest, src_a, src_b;
  src_use_t         src_use;

  assign opcode = if_instr[OPC_MSB:OPC_LSB];
  assign dest   = REG_W'(if_instr[DEST_MSB:DEST_LSB]);
  assign src_a  = REG_W'(if_instr[SRCA_MSB:SRCA_LSB]);
  assign src_b  = REG_W'(if_instr[SRCB_MSB:SRCB_LSB]);

  cpu_src_decode u_src_decode (
    .opcode  (opcode),
    .src_use (src_use)
  );

  always_comb begin
    a_busy = src_use.use_a && (pending[src_a] != '0);
    b_busy = src_use.use_b && (pending[src_b] != '0);
`ifdef CPU_HAZARD_WB_BYPASS_EN
    // Last outstanding write retiring now: the register file writes through.
    if (wb_wrt_en && (wb_wrt_reg == src_a) && (pending[src_a] == CNT_W'(1))) a_busy = 1'b0;
    if (wb_wrt_en && (wb_wrt_reg == src_b) && (pending[src_b] == CNT_W'(1))) b_busy = 1'b0;
`endif
  end

  assign rd_wrt_stall = if_valid && (a_busy || b_busy);
  assign jb_stall     = (jb_cnt != '0);
  assign issue_fire   = if_valid && !rd_wrt_stall && !jb_stall;

  always_comb begin
    err_set = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc            = issue_fire && if_wrt_en && (dest == REG_W'(r));
      dec            = wb_wrt_en && (wb_wrt_reg == REG_W'(r));
      pending_nxt[r] = pending[r];
      if (flush) begin
        pending_nxt[r] = '0;
      end else if (inc && !dec) begin
        if (pending[r] == CNT_W'(PIPE_DEPTH)) err_set = 1'b1;
        else                                   pending_nxt[r] = pending[r] + 1'b1;
      end else if (dec && !inc) begin
        if (pending[r] == '0) err_set = 1'b1;
        else                  pending_nxt[r] = pending[r] - 1'b1;
      end
    end
  end

  // A same-cycle load wins over jb_resolve; resolve wins over the countdown.
  always_comb begin
    jb_nxt = jb_cnt;
    if (flush)                     jb_nxt = '0;
    else if (issue_fire && if_jb)  jb_nxt = JB_W'(JB_STALL_CYCLES);
    else if (jb_resolve)           jb_nxt = '0;
    else if (jb_cnt != '0)         jb_nxt = jb_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pending[r] <= '0;
      jb_cnt <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pending[r] <= pending_nxt[r];
      jb_cnt <= jb_nxt;
      if (err_set) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_hazard_sb.sv
// Directed table-driven bench for cpu_hazard_sb (default parameters).
module tb_cpu_hazard_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_wrt_en;
  logic        if_jb;
  logic        wb_wrt_en;
  logic [3:0]  wb_wrt_reg;
  logic        jb_resolve;
  logic        flush;
  logic        issue_fire, rd_wrt_stall, jb_stall, sb_err;

  int checks = 0;
  int errors = 0;

`ifdef CPU_HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_hazard_sb #(.NUM_REGS(16), .PIPE_DEPTH(3), .JB_STALL_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_wrt_en    (if_wrt_en),
    .if_jb        (if_jb),
    .wb_wrt_en    (wb_wrt_en),
    .wb_wrt_reg   (wb_wrt_reg),
    .jb_resolve   (jb_resolve),
    .flush        (flush),
    .issue_fire   (issue_fire),
    .rd_wrt_stall (rd_wrt_stall),
    .jb_stall     (jb_stall),
    .sb_err       (sb_err)
  );

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        wrt;
    logic        jb;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic        resolve;
    logic        flush;
    logic        e_fire;
    logic        e_rd;
    logic        e_jb;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ins(logic [7:0] op, logic [3:0] d, logic [3:0] a, logic [3:0] b);
    return {op, d, a, b, 12'h000};
  endfunction

  task automatic addv(input logic v, input logic [31:0] i, input logic w, input logic j,
                      input logic we, input logic [3:0] wr, input logic res, input logic fl,
                      input logic ef, input logic er, input logic ej, input logic ee);
    vec_t t;
    t.valid = v; t.instr = i; t.wrt = w; t.jb = j; t.wb_en = we; t.wb_reg = wr;
    t.resolve = res; t.flush = fl; t.e_fire = ef; t.e_rd = er; t.e_jb = ej; t.e_err = ee;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic w, input logic j,
                       input logic we, input logic [3:0] wr, input logic res, input logic fl);
    if_valid = v; if_instr = i; if_wrt_en = w; if_jb = j;
    wb_wrt_en = we; wb_wrt_reg = wr; jb_resolve = res; flush = fl;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ef, input logic er, input logic ej, input logic ee);
    chk({tag, " issue_fire"},   issue_fire,   ef);
    chk({tag, " rd_wrt_stall"}, rd_wrt_stall, er);
    chk({tag, " jb_stall"},     jb_stall,     ej);
    chk({tag, " sb_err"},       sb_err,       ee);
  endtask

  initial begin
    drive(0, 32'h0, 0, 0, 0, 4'h0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //   valid instr                wrt jb we wr  res fl   fire rd   jb err
    addv(0, 32'h0,                  0, 0, 0, 4'd0, 0, 0,   0,   0,   0, 0); // reset state
    // data hazard on R3
    addv(1, ins(8'h10, 3, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h11, 4, 3, 0),    0, 0, 0, 4'd0, 0, 0,   0,   1,   0, 0);
    addv(1, ins(8'h11, 4, 3, 0),    0, 0, 0, 4'd0, 0, 0,   0,   1,   0, 0);
    addv(1, ins(8'h11, 4, 3, 0),    0, 0, 1, 4'd3, 0, 0,   BYP, !BYP, 0, 0);
    addv(1, ins(8'h11, 4, 3, 0),    0, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    // three writes in flight to R5
    addv(1, ins(8'h10, 5, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h10, 5, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h10, 5, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h13, 0, 5, 0),    0, 0, 1, 4'd5, 0, 0,   0,   1,   0, 0);
    addv(1, ins(8'h13, 0, 5, 0),    0, 0, 1, 4'd5, 0, 0,   0,   1,   0, 0);
    addv(1, ins(8'h13, 0, 5, 0),    0, 0, 1, 4'd5, 0, 0,   BYP, !BYP, 0, 0);
    addv(1, ins(8'h13, 0, 5, 0),    0, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    // src B of an R-type, and an opcode that reads nothing
    addv(1, ins(8'h10, 6, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h20, 0, 0, 6),    0, 0, 0, 4'd0, 0, 0,   0,   1,   0, 0);
    addv(1, ins(8'h30, 0, 6, 6),    0, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(0, 32'h0,                  0, 0, 1, 4'd6, 0, 0,   0,   0,   0, 0);
    // jump/branch: exactly two stall cycles
    addv(1, ins(8'h30, 0, 0, 0),    0, 1, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h30, 0, 0, 0),    0, 0, 0, 4'd0, 0, 0,   0,   0,   1, 0);
    addv(0, 32'h0,                  0, 0, 0, 4'd0, 0, 0,   0,   0,   1, 0);
    addv(1, ins(8'h30, 0, 0, 0),    0, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    // early resolve
    addv(1, ins(8'h30, 0, 0, 0),    0, 1, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(0, 32'h0,                  0, 0, 0, 4'd0, 1, 0,   0,   0,   1, 0);
    addv(0, 32'h0,                  0, 0, 0, 4'd0, 0, 0,   0,   0,   0, 0);
    // same-cycle inc/dec on R2
    addv(1, ins(8'h10, 2, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h10, 2, 0, 0),    1, 0, 1, 4'd2, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h11, 0, 2, 0),    0, 0, 0, 4'd0, 0, 0,   0,   1,   0, 0);
    addv(0, 32'h0,                  0, 0, 1, 4'd2, 0, 0,   0,   0,   0, 0);
    addv(1, ins(8'h11, 0, 2, 0),    0, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    // saturation: four writes to R1 with depth 3
    addv(1, ins(8'h10, 1, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h10, 1, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h10, 1, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h10, 1, 0, 0),    1, 0, 0, 4'd0, 0, 0,   1,   0,   0, 0);
    addv(1, ins(8'h11, 0, 1, 0),    0, 0, 1, 4'd1, 0, 0,   0,   1,   0, 1);
    addv(1, ins(8'h11, 0, 1, 0),    0, 0, 1, 4'd1, 0, 0,   0,   1,   0, 1);
    addv(1, ins(8'h11, 0, 1, 0),    0, 0, 1, 4'd1, 0, 0,   BYP, !BYP, 0, 1);
    addv(1, ins(8'h11, 0, 1, 0),    0, 0, 0, 4'd0, 0, 0,   1,   0,   0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].instr, vecs[i].wrt, vecs[i].jb,
            vecs[i].wb_en, vecs[i].wb_reg, vecs[i].resolve, vecs[i].flush);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_fire, vecs[i].e_rd, vecs[i].e_jb, vecs[i].e_err);
    end

    // flush with a pending write on R8 and an active jb stall
    @(negedge clk); drive(1, ins(8'h10, 8, 0, 0), 1, 0, 0, 4'd0, 0, 0);
    @(negedge clk); drive(1, ins(8'h30, 0, 0, 0), 0, 1, 0, 4'd0, 0, 0);
    @(negedge clk); drive(1, ins(8'h11, 0, 8, 0), 0, 0, 0, 4'd0, 0, 0);
    #1 chk_all("pre_flush", 0, 1, 1, 1);
    @(negedge clk); drive(1, ins(8'h11, 0, 8, 0), 0, 0, 0, 4'd0, 0, 1);
    @(negedge clk); drive(1, ins(8'h11, 0, 8, 0), 0, 0, 0, 4'd0, 0, 0);
    #1 chk_all("post_flush", 1, 0, 0, 1);

    // asynchronous reset mid-stall
    @(negedge clk); drive(1, ins(8'h10, 9, 0, 0), 1, 0, 0, 4'd0, 0, 0);
    @(negedge clk); drive(1, ins(8'h30, 0, 0, 0), 0, 1, 0, 4'd0, 0, 0);
    @(negedge clk); drive(1, ins(8'h11, 0, 9, 0), 0, 0, 0, 4'd0, 0, 0);
    #1 chk_all("pre_rst", 0, 1, 1, 1);
    #1 rst_n = 1'b0;
    #1 chk_all("async_rst_valid", 1, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0, 4'd0, 0, 0);
    #1 chk_all("async_rst_idle", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // underflow on R7 is sticky through flush
    @(negedge clk); drive(0, 32'h0, 0, 0, 1, 4'd7, 0, 0);
    #1 chk("underflow_pre sb_err", sb_err, 1'b0);
    @(negedge clk); drive(0, 32'h0, 0, 0, 0, 4'd0, 0, 0);
    #1 chk("underflow sb_err", sb_err, 1'b1);
    @(negedge clk); drive(0, 32'h0, 0, 0, 0, 4'd0, 0, 1);
    @(negedge clk); drive(1, ins(8'h11, 0, 7, 0), 0, 0, 0, 4'd0, 0, 0);
    #1 chk_all("after_flush_err", 1, 0, 0, 1);

    @(negedge clk); drive(0, 32'h0, 0, 0, 0, 4'd0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
